// File: rtl/mem_rr_arbiter.sv
// Round-robin memory arbiter: shares one memory slave port between CNT masters.
// Grants rotate fairly, stay locked to one master while the slave stalls, and
// are capped per master by an outstanding-request limit. Responses come back
// in order and are steered to the issuing master through a route queue.
//
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   master_req_valid/ready/data  [CNT]     requests from the masters
//   master_resp_valid/ready/data [CNT]     responses routed back to the masters
//   slave_req_valid/ready/data             request to the memory slave
//   slave_resp_valid/ready/data            in-order responses from the slave
//   busy                                   a request is in flight or granted-but-unfired
//
// state  | meaning
// S_IDLE | arbitrate among eligible masters every cycle
// S_HOLD | slave stalled a grant; selection frozen to gnt_q until it fires
module mem_rr_arbiter #(
  parameter int CNT             = 3,
  parameter int QUEUE_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int REQ_W           = 32,
  parameter int RESP_W          = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CNT-1:0]             master_req_valid,
  output logic [CNT-1:0]             master_req_ready,
  input  logic [CNT-1:0][REQ_W-1:0]  master_req_data,
  output logic [CNT-1:0]             master_resp_valid,
  input  logic [CNT-1:0]             master_resp_ready,
  output logic [CNT-1:0][RESP_W-1:0] master_resp_data,
  output logic                       slave_req_valid,
  input  logic                       slave_req_ready,
  output logic [REQ_W-1:0]           slave_req_data,
  input  logic                       slave_resp_valid,
  output logic                       slave_resp_ready,
  input  logic [RESP_W-1:0]          slave_resp_data,
  output logic                       busy
);

  localparam int IDX_W = $clog2(CNT);
  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int QC_W  = $clog2(QUEUE_DEPTH + 1);

  localparam logic [CW-1:0]    MAX_C    = CW'(MAX_OUTSTANDING);
  localparam logic [QC_W-1:0]  DEPTH_C  = QC_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_q, gnt_q, gnt_d;
  logic [CW-1:0]    cnt_q [CNT];
  logic [IDX_W-1:0] q_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [QC_W-1:0]  q_count;

  logic             q_full, q_empty;
  logic [CNT-1:0]   eligible;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             req_fire, resp_fire, have_head;
  logic [IDX_W-1:0] head_idx;
  logic [CNT-1:0]   cnt_inc, cnt_dec;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    q_full  = (q_count == DEPTH_C);
    q_empty = (q_count == '0);
    for (int i = 0; i < CNT; i++) begin
      eligible[i] = master_req_valid[i] && (cnt_q[i] < MAX_C) && !q_full;
    end
  end

  // Rotating priority: scan last+1, last+2, ... wrapping at CNT.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cidx;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cidx       = '0;
    for (int k = 1; k <= CNT; k++) begin
      cand = int'(last_q) + k;
      if (cand >= CNT) cand = cand - CNT;
      cidx = IDX_W'(cand);
      if (!pick_found && eligible[cidx]) begin
        pick_found = 1'b1;
        pick_idx   = cidx;
      end
    end
  end

  always_comb begin
    sel_valid = pick_found;
    sel_idx   = pick_idx;
    if (state_q == S_HOLD) begin
      sel_valid = 1'b1;
      sel_idx   = gnt_q;
    end
    if (rst) sel_valid = 1'b0;
  end

  assign slave_req_valid = sel_valid;
  assign slave_req_data  = master_req_data[sel_idx];
  assign req_fire        = sel_valid && slave_req_ready;

  // With an empty queue the route entry falls through from the request being
  // fired this cycle, so a zero-latency slave response can be routed at once.
  assign have_head        = !rst && (!q_empty || req_fire);
  assign head_idx         = q_empty ? sel_idx : q_mem[rd_ptr];
  assign slave_resp_ready = have_head && master_resp_ready[head_idx];
  assign resp_fire        = slave_resp_valid && slave_resp_ready;
  assign busy             = !rst && ((state_q == S_HOLD) || !q_empty);

  always_comb begin
    for (int i = 0; i < CNT; i++) begin
      master_req_ready[i]  = req_fire && (sel_idx == IDX_W'(i));
      master_resp_valid[i] = slave_resp_valid && have_head && (head_idx == IDX_W'(i));
      master_resp_data[i]  = slave_resp_data;
      cnt_inc[i]           = req_fire && (sel_idx == IDX_W'(i));
      cnt_dec[i]           = resp_fire && (head_idx == IDX_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found && !slave_req_ready) begin
          state_d = S_HOLD;
          gnt_d   = pick_idx;
        end
      end
      S_HOLD: begin
        if (slave_req_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(CNT - 1);
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
      for (int i = 0; i < CNT; i++) cnt_q[i] <= '0;
      for (int j = 0; j < QUEUE_DEPTH; j++) q_mem[j] <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      if (req_fire) last_q <= sel_idx;

      // Empty queue with request and response in the same cycle: the entry
      // bypasses storage entirely.
      if (req_fire && !(q_empty && resp_fire)) begin
        q_mem[wr_ptr] <= sel_idx;
        wr_ptr        <= ptr_next(wr_ptr);
      end
      if (resp_fire && !q_empty) rd_ptr <= ptr_next(rd_ptr);

      if (req_fire && !resp_fire)      q_count <= q_count + 1'b1;
      else if (resp_fire && !req_fire) q_count <= q_count - 1'b1;

      for (int i = 0; i < CNT; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (cnt_dec[i] && !cnt_inc[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
module tb_mem_rr_arbiter;

  localparam int CNT = 3;
  localparam logic [31:0] K = 32'h5A5A_0000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [CNT-1:0]        master_req_valid;
  logic [CNT-1:0]        master_req_ready;
  logic [CNT-1:0][31:0]  master_req_data;
  logic [CNT-1:0]        master_resp_valid;
  logic [CNT-1:0]        master_resp_ready;
  logic [CNT-1:0][31:0]  master_resp_data;
  logic                  slave_req_valid;
  logic                  slave_req_ready;
  logic [31:0]           slave_req_data;
  logic                  slave_resp_valid;
  logic                  slave_resp_ready;
  logic [31:0]           slave_resp_data;
  logic                  busy;

  mem_rr_arbiter #(
    .CNT(3), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(2), .REQ_W(32), .RESP_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .master_req_valid(master_req_valid), .master_req_ready(master_req_ready),
    .master_req_data(master_req_data),
    .master_resp_valid(master_resp_valid), .master_resp_ready(master_resp_ready),
    .master_resp_data(master_resp_data),
    .slave_req_valid(slave_req_valid), .slave_req_ready(slave_req_ready),
    .slave_req_data(slave_req_data),
    .slave_resp_valid(slave_resp_valid), .slave_resp_ready(slave_resp_ready),
    .slave_resp_data(slave_resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [39:0] exp_grant[$];
  logic [39:0] exp_resp[$];
  logic [31:0] pend[$];
  logic        resp_en = 1'b0;
  logic [7:0]  tag = 8'h00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input int i);
    return {tag, 16'h0000, 8'(i)};
  endfunction

  task automatic set_data();
    for (int i = 0; i < CNT; i++) master_req_data[i] = mdata(i);
  endtask

  task automatic push_grant(input int i);
    exp_grant.push_back({8'(i), mdata(i)});
  endtask

  task automatic push_resp(input int i);
    exp_resp.push_back({8'(i), mdata(i) ^ K});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_sreq_valid"}, 64'(slave_req_valid), 64'(0));
    chk({name, "_mreq_ready"}, 64'(master_req_ready), 64'(0));
    chk({name, "_mresp_valid"}, 64'(master_resp_valid), 64'(0));
    chk({name, "_sresp_ready"}, 64'(slave_resp_ready), 64'(0));
    chk({name, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    mid();
    while ((busy || exp_resp.size() != 0 || exp_grant.size() != 0) && n < 60) begin
      tick();
      mid();
      n++;
    end
    chk({name, "_drain_timeout"}, 64'(n < 60), 64'(1));
    chk({name, "_busy_idle"}, 64'(busy), 64'(0));
  endtask

  // Scoreboard monitor: compares every fired request and response.
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (slave_req_valid && slave_req_ready) begin
        if (exp_grant.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: data 0x%0h ready %b, expected none", slave_req_data, master_req_ready);
        end else begin
          e = exp_grant.pop_front();
          chk("grant_data", 64'(slave_req_data), 64'(e[31:0]));
          chk("grant_ready", 64'(master_req_ready), 64'(1) << e[39:32]);
        end
      end
      for (int i = 0; i < CNT; i++) begin
        if (master_resp_valid[i] && master_resp_ready[i]) begin
          if (exp_resp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: master %0d data 0x%0h, expected none", i, master_resp_data[i]);
          end else begin
            e = exp_resp.pop_front();
            chk("resp_master", 64'(i), 64'(e[39:32]));
            chk("resp_data", 64'(master_resp_data[i]), 64'(e[31:0]));
          end
        end
      end
      if (slave_resp_valid && !rst)
        chk("resp_onehot", 64'($countones(master_resp_valid) <= 1), 64'(1));
    end
  end

  // Slave model: answers each request one cycle later, in order, when enabled.
  initial begin
    logic fired;
    slave_resp_valid = 1'b0;
    slave_resp_data  = '0;
    forever begin
      @(negedge clk);
      fired = slave_resp_valid && slave_resp_ready;
      if (rst) pend.delete();
      else if (slave_req_valid && slave_req_ready) pend.push_back(slave_req_data ^ K);
      @(posedge clk);
      #2;
      if (fired && pend.size() > 0) void'(pend.pop_front());
      slave_resp_valid = resp_en && (pend.size() > 0);
      slave_resp_data  = (pend.size() > 0) ? pend[0] : 32'h0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst               = 1'b1;
    master_req_valid  = '1;
    master_resp_ready = '1;
    slave_req_ready   = 1'b1;
    tag               = 8'h10;
    set_data();
    repeat (2) @(posedge clk);
    #4;
    chk_quiet("t0_reset");
    tick();
    rst              = 1'b0;
    master_req_valid = '0;

    // t1: all masters valid, slave always ready -> 0,1,2,0,1,2
    tick();
    tag = 8'h21;
    set_data();
    resp_en          = 1'b1;
    master_req_valid = 3'b111;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < CNT; i++) begin
        push_grant(i);
        push_resp(i);
      end
    repeat (6) tick();
    master_req_valid = '0;
    chk("t1_all_granted", 64'(exp_grant.size()), 64'(0));
    drain("t1");

    // t2: grant locked while slave stalls, master 0 arrives mid-hold
    tick();
    tag = 8'h32;
    set_data();
    master_req_valid = 3'b010;
    slave_req_ready  = 1'b0;
    push_grant(1); push_grant(0);
    push_resp(1);  push_resp(0);
    for (int c = 1; c <= 3; c++) begin
      mid();
      chk("t2_hold_valid", 64'(slave_req_valid), 64'(1));
      chk("t2_hold_data", 64'(slave_req_data), 64'(mdata(1)));
      chk("t2_hold_no_ready", 64'(master_req_ready), 64'(0));
      tick();
      if (c == 1) master_req_valid[0] = 1'b1;
    end
    slave_req_ready = 1'b1;
    mid();
    chk("t2_fire_data", 64'(slave_req_data), 64'(mdata(1)));
    chk("t2_fire_m1", 64'(master_req_ready), 64'(3'b010));
    tick();
    master_req_valid[1] = 1'b0;
    mid();
    chk("t2_next_m0", 64'(master_req_ready), 64'(3'b001));
    tick();
    master_req_valid = '0;
    drain("t2");

    // t3: outstanding cap of 2 with a silent slave
    tick();
    tag = 8'h43;
    set_data();
    resp_en          = 1'b0;
    master_req_valid = 3'b001;
    repeat (3) begin push_grant(0); push_resp(0); end
    tick();
    tick();
    mid();
    chk("t3_capped_valid", 64'(slave_req_valid), 64'(0));
    chk("t3_capped_busy", 64'(busy), 64'(1));
    tick();
    mid();
    chk("t3_capped_valid2", 64'(slave_req_valid), 64'(0));
    tick();
    resp_en = 1'b1;
    mid();
    chk("t3_one_resp", 64'(master_resp_valid), 64'(3'b001));
    chk("t3_still_capped", 64'(slave_req_valid), 64'(0));
    tick();
    resp_en = 1'b0;
    mid();
    chk("t3_third_fire", 64'(master_req_ready), 64'(3'b001));
    tick();
    mid();
    chk("t3_capped_again", 64'(slave_req_valid), 64'(0));
    tick();
    master_req_valid = '0;
    resp_en          = 1'b1;
    drain("t3");

    // t4: route queue full after 4 fires (reset first so master 0 leads)
    tick();
    rst = 1'b1;
    mid();
    chk_quiet("t4_reset");
    tick();
    rst = 1'b0;
    tag = 8'h54;
    set_data();
    resp_en          = 1'b0;
    master_req_valid = 3'b111;
    push_grant(0); push_grant(1); push_grant(2); push_grant(0);
    push_resp(0);  push_resp(1);  push_resp(2);  push_resp(0);
    repeat (4) tick();
    mid();
    chk("t4_full_no_valid", 64'(slave_req_valid), 64'(0));
    chk("t4_full_busy", 64'(busy), 64'(1));
    chk("t4_full_no_ready", 64'(master_req_ready), 64'(0));
    tick();
    mid();
    chk("t4_full_no_valid2", 64'(slave_req_valid), 64'(0));
    tick();
    master_req_valid = '0;
    resp_en          = 1'b1;
    drain("t4");

    // t5: issue 0,2,1; master 2 stalls its response for 2 cycles
    tick();
    tag = 8'h65;
    set_data();
    resp_en = 1'b0;
    push_grant(0); push_grant(2); push_grant(1);
    push_resp(0);  push_resp(2);  push_resp(1);
    master_req_valid = 3'b001;
    tick();
    master_req_valid = 3'b100;
    tick();
    master_req_valid = 3'b010;
    tick();
    master_req_valid  = '0;
    resp_en           = 1'b1;
    master_resp_ready = 3'b011;
    mid();
    chk("t5_r0_route", 64'(master_resp_valid), 64'(3'b001));
    for (int c = 0; c < 2; c++) begin
      tick();
      mid();
      chk("t5_r2_route", 64'(master_resp_valid), 64'(3'b100));
      chk("t5_r2_stall", 64'(slave_resp_ready), 64'(0));
    end
    tick();
    master_resp_ready = 3'b111;
    mid();
    chk("t5_r2_release", 64'(slave_resp_ready), 64'(1));
    tick();
    drain("t5");

    // t6: reset with 3 in flight and a held grant
    tick();
    tag = 8'h76;
    set_data();
    resp_en          = 1'b0;
    master_req_valid = 3'b111;
    slave_req_ready  = 1'b1;
    push_grant(2); push_grant(0); push_grant(1);
    repeat (3) tick();
    slave_req_ready = 1'b0;
    mid();
    chk("t6_hold_valid", 64'(slave_req_valid), 64'(1));
    chk("t6_hold_data", 64'(slave_req_data), 64'(mdata(2)));
    tick();
    mid();
    chk("t6_hold_data2", 64'(slave_req_data), 64'(mdata(2)));
    chk("t6_busy", 64'(busy), 64'(1));
    tick();
    rst = 1'b1;
    mid();
    chk_quiet("t6_in_reset");
    tick();
    mid();
    chk_quiet("t6_after_reset");
    tick();
    rst             = 1'b0;
    slave_req_ready = 1'b1;
    push_grant(0);
    push_resp(0);
    mid();
    chk("t6_m0_first", 64'(master_req_ready), 64'(3'b001));
    tick();
    master_req_valid = '0;
    resp_en          = 1'b1;
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
Round-robin memory arbiter that shares one memory slave port between CNT masters, for cases where fixed priority would starve low-priority requesters (e.g. I-fetch vs. LSU vs. PTW).
- Grants are fair (rotating priority), locked across backpressure, and capped per master by an outstanding-request limit.
- Responses return in order and are routed back to the issuing master through an internal route queue.
- Sits between the core memory clients and the bus/cache slave port.

Parameters:
CNT, 3, number of master ports (>=2)
QUEUE_DEPTH, 4, route queue depth = max total in-flight requests
MAX_OUTSTANDING, 2, max in-flight requests per master (1..QUEUE_DEPTH)

Ports:
clk  input  1  clock; single clock domain
rst  input  1  synchronous, active-high reset
master_req[CNT]  decoupled.in  mreq  master requests
master_resp[CNT]  decoupled.out  mresp  responses routed to masters
slave_req  decoupled.out  mreq  request to memory slave
slave_resp  decoupled.in  mresp  in-order responses from slave
busy  output  1  high when any request is in flight or granted-but-unfired

Behaviour:
- Reset (rst high, synchronous):
  - pointer last := CNT-1, so master 0 has top priority first.
  - all outstanding counters := 0; route queue emptied; FSM := IDLE.
  - While rst is high: slave_req.valid=0, slave_resp.ready=0, all master_req.ready=0, all master_resp.valid=0, busy=0.
  - Reset mid-transaction drops all in-flight routing state. The slave is reset in the same cycle.
- Eligibility: master i is eligible iff master_req[i].valid && cnt[i] < MAX_OUTSTANDING && route queue not full.
- FSM IDLE:
  - Pick the first eligible i scanning last+1, last+2, ... modulo CNT.
  - Drive slave_req.valid=1 and slave_req.data=master_req[i].data combinationally.
  - If slave_req.ready: fire. master_req[i].ready=1, enqueue i into the route queue, cnt[i]++, last:=i; stay in IDLE.
  - Else: latch gnt:=i and go to HOLD.
- FSM HOLD:
  - Selection is frozen to gnt; slave_req.valid=1 and data=master_req[gnt].data, independent of other masters.
  - On fire: same updates as IDLE, last:=gnt, return to IDLE.
  - Masters must keep valid/data stable until fire (decoupled rule); the arbiter does not re-arbitrate in HOLD.
- master_req[j].ready=0 for every j other than the firing master.
- Route queue: FIFO of $clog2(CNT)-bit indices with fallthrough, so a response may fire in the same cycle as its request.
- Response path:
  - master_resp[i].valid = slave_resp.valid && queue non-empty && head==i.
  - master_resp[i].data = slave_resp.data for all i.
  - slave_resp.ready = queue non-empty && master_resp[head].ready.
  - On slave_resp fire: dequeue and cnt[head]--.
  - slave_resp.valid while the queue is empty is a slave protocol error: ignored, ready stays 0.
- Counters: same-cycle inc and dec on the same master leaves cnt unchanged. Width $clog2(MAX_OUTSTANDING+1); never wraps given eligibility.
- Queue full: no new grant. A HOLD grant cannot exist with a full queue, because the HOLD entry already required a free slot and responses only free slots.
- busy = (state==HOLD) || queue non-empty.
- Latency: zero-cycle combinational path master->slave request and slave->master response; no added pipeline stage.

Test Plan:
- Masters 0,1,2 all valid continuously, slave always ready and responds next cycle -> grant order 0,1,2,0,1,2; each master gets exactly one fire per 3 cycles.
- Master 1 valid; slave_req.ready held low 3 cycles while master 0 raises valid in cycle 2 -> slave_req.data stays master 1's for all 4 cycles; master 1 fires in cycle 4; master 0 fires next.
- MAX_OUTSTANDING=2, slave never responds, only master 0 valid -> exactly 2 fires, then slave_req.valid=0. After one response to master 0, a third fire occurs.
- QUEUE_DEPTH=4, no responses, all masters valid -> 4 fires total (two to master 0, one each to 1 and 2), then busy=1 and no further grants.
- Issue 0,2,1 with responses R0,R2,R1; stall master_resp[2].ready 2 cycles -> R0 to master 0; R2 held with slave_resp.ready=0 until ready, then delivered to 2; R1 to 1; counters return to 0, busy=0.
- Assert rst with 3 requests in flight and state HOLD -> next cycle all valids/readies 0, busy=0. After rst drops, master 0 is granted first.
